// File: rtl/frame_pkt_buf.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// frame_pkt_buf : strips frame headers, stores complete payloads in a circular
// byte buffer and replays them as a valid/ready byte stream with tlast/length.
// Revision: 1.0
// ============================================================================
module frame_pkt_buf #(
    parameter int BUF_AW        = 12,
    parameter int LEN_FIFO_AW   = 4,
    parameter int HDR_BYTES     = 4,
    parameter int FRAME_MAX_LEN = 1540
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic [7:0]  frame_data,
    input  logic        data_vld,
    input  logic [15:0] frame_len,
    input  logic        len_vld,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    output logic        m_tlast,
    output logic [15:0] m_tlen,
    input  logic        m_tready,
    output logic [15:0] frame_cnt,
    output logic [15:0] drop_cnt,
    output logic        err_trunc
);
    localparam int                     DEPTH    = 2**BUF_AW;
    localparam int                     LF_DEPTH = 2**LEN_FIFO_AW;
    localparam logic [BUF_AW:0]        DEPTH_P  = DEPTH;
    localparam logic [BUF_AW:0]        PTR_ONE  = 1;
    localparam logic [LEN_FIFO_AW:0]   LF_ONE   = 1;
    localparam logic [15:0]            HDR_L    = 16'(HDR_BYTES);
    localparam logic [15:0]            MAX_L    = 16'(FRAME_MAX_LEN);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_DROP = 2'd2} wstate_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_LOAD = 2'd1, R_DATA = 2'd2} rstate_t;

    logic [7:0]  mem    [DEPTH];
    logic [15:0] lf_mem [LF_DEPTH];
    logic [7:0]  ram_q;

    wstate_t              wst_q, wst_d;
    rstate_t              rdst_q, rdst_d;
    logic [BUF_AW:0]      wr_ptr_q, wr_ptr_d, wr_commit_q, wr_commit_d;
    logic [BUF_AW:0]      rd_ptr_q, rd_ptr_d, rd_addr_q, rd_addr_d;
    logic [LEN_FIFO_AW:0] lf_wp_q, lf_wp_d, lf_rp_q, lf_rp_d;
    logic [15:0]          idx_q, idx_d, flen_q, flen_d, plen_q, plen_d;
    logic [15:0]          iss_rem_q, iss_rem_d, tlen_q, tlen_d;
    logic [15:0]          fcnt_q, fcnt_d, dcnt_q, dcnt_d;
    logic                 err_q, err_d;
    logic                 infl_q, infl_last_q;
    logic                 out_vld_q, out_last_q, skid_vld_q, skid_last_q;
    logic [7:0]           out_data_q, skid_data_q;

    logic                     w_end, w_commit, w_trunc, w_bad, w_wr_en;
    logic [BUF_AW:0]          w_wr_eff, w_free;
    logic [15:0]              w_plen, w_lf_head;
    logic [LEN_FIFO_AW+1:0]   w_lf_lvl;
    logic [1:0]               w_drop_add, w_occ;
    logic [16:0]              w_dsum;
    logic                     w_pop, w_lacc, w_rstart, w_more, w_issue, w_iss_last;

    // Write side: header strip, admission check, commit or roll back at frame end
    always_comb begin
        w_end    = (wst_q != W_IDLE) && (!data_vld || len_vld);
        w_commit = (wst_q == W_DATA) && w_end && (idx_q == flen_q);
        w_trunc  = (wst_q == W_DATA) && w_end && (idx_q != flen_q);
        w_wr_eff = w_trunc ? wr_commit_q : wr_ptr_q;
        w_free   = DEPTH_P - (w_wr_eff - rd_ptr_q);
        w_plen   = frame_len - HDR_L;
        w_lf_lvl = {1'b0, lf_wp_q - lf_rp_q} + {{(LEN_FIFO_AW+1){1'b0}}, w_commit};
        w_bad    = (frame_len <= HDR_L) || (frame_len > MAX_L)
                || (32'(w_plen) > 32'(w_free)) || (32'(w_lf_lvl) >= 32'(LF_DEPTH));
        w_wr_en  = (wst_q == W_DATA) && !w_end && (idx_q < flen_q) && (idx_q >= HDR_L);
        w_drop_add = 2'(w_trunc) + 2'(len_vld && w_bad);
        w_dsum   = {1'b0, dcnt_q} + 17'(w_drop_add);
        dcnt_d   = w_dsum[16] ? 16'hFFFF : w_dsum[15:0];

        wst_d       = wst_q;
        idx_d       = idx_q;
        flen_d      = flen_q;
        plen_d      = plen_q;
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        lf_wp_d     = lf_wp_q;
        err_d       = w_trunc;
        if (w_commit) begin
            wr_commit_d = wr_ptr_q;
            lf_wp_d     = lf_wp_q + LF_ONE;
        end
        if (w_trunc)
            wr_ptr_d = wr_commit_q;
        // The first byte always falls inside the header, so a new frame starts at index 1
        if (len_vld) begin
            idx_d  = 16'd1;
            flen_d = frame_len;
            plen_d = w_plen;
            wst_d  = w_bad ? W_DROP : W_DATA;
        end else if (w_end) begin
            wst_d = W_IDLE;
        end else if ((wst_q == W_DATA) && (idx_q < flen_q)) begin
            idx_d = idx_q + 16'd1;
            if (w_wr_en)
                wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
    end

    // Read side: issue RAM reads only while output register + skid can absorb them
    always_comb begin
        w_pop      = out_vld_q && m_tready;
        w_lacc     = w_pop && out_last_q;
        w_lf_head  = lf_mem[lf_rp_q[LEN_FIFO_AW-1:0]];
        w_rstart   = (lf_wp_q != lf_rp_q) && ((rdst_q == R_IDLE) || w_lacc);
        w_occ      = 2'(out_vld_q) + 2'(skid_vld_q) + 2'(infl_q);
        w_more     = (rdst_q != R_IDLE) && (iss_rem_q != 16'd0)
                  && (w_occ <= (w_pop ? 2'd2 : 2'd1));
        w_issue    = w_rstart || w_more;
        w_iss_last = w_rstart ? (w_lf_head == 16'd1) : (iss_rem_q == 16'd1);

        rdst_d    = rdst_q;
        iss_rem_d = iss_rem_q;
        tlen_d    = tlen_q;
        lf_rp_d   = lf_rp_q;
        rd_addr_d = rd_addr_q;
        rd_ptr_d  = rd_ptr_q;
        fcnt_d    = fcnt_q;
        if (w_pop)
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (w_issue)
            rd_addr_d = rd_addr_q + PTR_ONE;
        if (w_more)
            iss_rem_d = iss_rem_q - 16'd1;
        if (w_lacc && (fcnt_q != 16'hFFFF))
            fcnt_d = fcnt_q + 16'd1;
        if (w_rstart) begin
            lf_rp_d   = lf_rp_q + LF_ONE;
            tlen_d    = w_lf_head;
            iss_rem_d = w_lf_head - 16'd1;
            rdst_d    = R_LOAD;
        end else if (w_lacc) begin
            rdst_d = R_IDLE;
        end else if (rdst_q == R_LOAD) begin
            rdst_d = R_DATA;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_wr_en)
            mem[wr_ptr_q[BUF_AW-1:0]] <= frame_data;
        if (w_commit)
            lf_mem[lf_wp_q[LEN_FIFO_AW-1:0]] <= plen_q;
        ram_q <= mem[rd_addr_q[BUF_AW-1:0]];
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            wst_q       <= W_IDLE;
            rdst_q      <= R_IDLE;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            rd_ptr_q    <= '0;
            rd_addr_q   <= '0;
            lf_wp_q     <= '0;
            lf_rp_q     <= '0;
            idx_q       <= '0;
            flen_q      <= '0;
            plen_q      <= '0;
            iss_rem_q   <= '0;
            tlen_q      <= '0;
            fcnt_q      <= '0;
            dcnt_q      <= '0;
            err_q       <= 1'b0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            out_vld_q   <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            skid_vld_q  <= 1'b0;
            skid_last_q <= 1'b0;
            skid_data_q <= '0;
        end else begin
            wst_q       <= wst_d;
            rdst_q      <= rdst_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_addr_q   <= rd_addr_d;
            lf_wp_q     <= lf_wp_d;
            lf_rp_q     <= lf_rp_d;
            idx_q       <= idx_d;
            flen_q      <= flen_d;
            plen_q      <= plen_d;
            iss_rem_q   <= iss_rem_d;
            tlen_q      <= tlen_d;
            fcnt_q      <= fcnt_d;
            dcnt_q      <= dcnt_d;
            err_q       <= err_d;
            infl_q      <= w_issue;
            infl_last_q <= w_iss_last;
            if (w_pop) begin
                if (skid_vld_q) begin
                    out_data_q  <= skid_data_q;
                    out_last_q  <= skid_last_q;
                    skid_vld_q  <= infl_q;
                    skid_data_q <= ram_q;
                    skid_last_q <= infl_last_q;
                end else begin
                    out_vld_q  <= infl_q;
                    out_data_q <= ram_q;
                    out_last_q <= infl_last_q;
                end
            end else if (infl_q) begin
                if (!out_vld_q) begin
                    out_vld_q  <= 1'b1;
                    out_data_q <= ram_q;
                    out_last_q <= infl_last_q;
                end else begin
                    skid_vld_q  <= 1'b1;
                    skid_data_q <= ram_q;
                    skid_last_q <= infl_last_q;
                end
            end
        end
    end

    assign m_tdata   = out_data_q;
    assign m_tvalid  = out_vld_q;
    assign m_tlast   = out_last_q;
    assign m_tlen    = tlen_q;
    assign frame_cnt = fcnt_q;
    assign drop_cnt  = dcnt_q;
    assign err_trunc = err_q;
endmodule
`default_nettype wire

// File: tb/tb_frame_pkt_buf.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_frame_pkt_buf : directed scenario bench for frame_pkt_buf.
// Revision: 1.0
// ============================================================================
module tb_frame_pkt_buf;
    localparam int HDR = 4;

    logic        sys_clk    = 1'b0;
    logic        rst        = 1'b1;
    logic [7:0]  frame_data = '0;
    logic        data_vld   = 1'b0;
    logic [15:0] frame_len  = '0;
    logic        len_vld    = 1'b0;
    logic        m_tready   = 1'b1;
    logic [7:0]  m_tdata;
    logic        m_tvalid, m_tlast, err_trunc;
    logic [15:0] m_tlen, frame_cnt, drop_cnt;

    int total = 0;
    int bad   = 0;

    logic [24:0] got_q[$];
    logic [24:0] exp_q[$];
    int          err_pulses = 0;
    int          stall_err  = 0;
    logic        prev_stall = 1'b0;
    logic [24:0] prev_word  = '0;

    frame_pkt_buf dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .frame_data (frame_data),
        .data_vld   (data_vld),
        .frame_len  (frame_len),
        .len_vld    (len_vld),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tlast    (m_tlast),
        .m_tlen     (m_tlen),
        .m_tready   (m_tready),
        .frame_cnt  (frame_cnt),
        .drop_cnt   (drop_cnt),
        .err_trunc  (err_trunc)
    );

    always #5 sys_clk = ~sys_clk;

    // Mid-cycle observer: inputs change just after posedge, so values here hold at the next edge
    always @(negedge sys_clk) begin
        if (m_tvalid && m_tready)
            got_q.push_back({m_tlen, m_tlast, m_tdata});
        if (err_trunc)
            err_pulses++;
        if (prev_stall && (!m_tvalid || ({m_tlen, m_tlast, m_tdata} !== prev_word)))
            stall_err++;
        prev_stall = m_tvalid && !m_tready;
        prev_word  = {m_tlen, m_tlast, m_tdata};
    end

    function automatic void add_exp(input int plen, input int seed);
        for (int j = 0; j < plen; j++)
            exp_q.push_back({16'(plen), (j == plen - 1), 8'(j + HDR + seed)});
    endfunction

    task automatic do_reset();
        rst = 1'b1; data_vld = 1'b0; len_vld = 1'b0; frame_data = '0; frame_len = '0;
        m_tready = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1 rst = 1'b0;
        @(posedge sys_clk); #1;
    endtask

    task automatic send_frame(input int flen, input int nb, input int seed, input int gap);
        for (int i = 0; i < nb; i++) begin
            frame_data = 8'(i + seed);
            data_vld   = 1'b1;
            len_vld    = (i == 0);
            frame_len  = 16'(flen);
            @(posedge sys_clk); #1;
        end
        len_vld = 1'b0;
        if (gap > 0) begin
            data_vld = 1'b0;
            repeat (gap) begin @(posedge sys_clk); #1; end
        end
    endtask

    task automatic wait_out(input int n, input int budget);
        int c = 0;
        while ((got_q.size() < n) && (c < budget)) begin
            @(posedge sys_clk); c++;
        end
        repeat (10) @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        int g0;
        rst = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        total++; if (m_tvalid !== 1'b0)    begin bad++; $display("FAIL rst_tvalid got=%b exp=0", m_tvalid); end
        total++; if (m_tdata !== 8'h00)    begin bad++; $display("FAIL rst_tdata got=%h exp=00", m_tdata); end
        total++; if (m_tlast !== 1'b0)     begin bad++; $display("FAIL rst_tlast got=%b exp=0", m_tlast); end
        total++; if (m_tlen !== 16'd0)     begin bad++; $display("FAIL rst_tlen got=%0d exp=0", m_tlen); end
        total++; if (frame_cnt !== 16'd0)  begin bad++; $display("FAIL rst_frame_cnt got=%0d exp=0", frame_cnt); end
        total++; if (drop_cnt !== 16'd0)   begin bad++; $display("FAIL rst_drop_cnt got=%0d exp=0", drop_cnt); end
        total++; if (err_trunc !== 1'b0)   begin bad++; $display("FAIL rst_err_trunc got=%b exp=0", err_trunc); end
        // Store one frame behind a stalled sink, then reset mid-way through the next
        do_reset();
        m_tready = 1'b0;
        g0 = got_q.size();
        send_frame(40, 40, 0, 4);
        total++; if (m_tvalid !== 1'b1)    begin bad++; $display("FAIL rst_pre_tvalid got=%b exp=1", m_tvalid); end
        total++; if (m_tlen !== 16'd36)    begin bad++; $display("FAIL rst_pre_tlen got=%0d exp=36", m_tlen); end
        send_frame(40, 20, 0, 0);
        rst = 1'b1; data_vld = 1'b0;
        #2;
        total++; if (m_tvalid !== 1'b0)    begin bad++; $display("FAIL rst_mid_tvalid got=%b exp=0", m_tvalid); end
        total++; if (m_tlen !== 16'd0)     begin bad++; $display("FAIL rst_mid_tlen got=%0d exp=0", m_tlen); end
        @(posedge sys_clk); #1;
        rst = 1'b0; m_tready = 1'b1;
        repeat (40) @(posedge sys_clk);
        #1;
        total++; if (got_q.size() != g0)   begin bad++; $display("FAIL rst_discard got=%0d exp=0 bytes", got_q.size() - g0); end
    endtask

    task automatic test_basic();
        int g0;
        do_reset();
        exp_q.delete();
        g0 = got_q.size();
        send_frame(40, 40, 0, 3);
        add_exp(36, 0);
        wait_out(g0 + 36, 200);
        total++; if (got_q.size() - g0 != exp_q.size()) begin bad++; $display("FAIL basic_count got=%0d exp=%0d", got_q.size() - g0, exp_q.size()); end
        for (int i = 0; (i < exp_q.size()) && (g0 + i < got_q.size()); i++) begin
            total++;
            if (got_q[g0 + i] !== exp_q[i]) begin bad++; $display("FAIL basic_byte%0d got=%h exp=%h", i, got_q[g0 + i], exp_q[i]); end
        end
        total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL basic_frame_cnt got=%0d exp=1", frame_cnt); end
        total++; if (drop_cnt !== 16'd0)  begin bad++; $display("FAIL basic_drop_cnt got=%0d exp=0", drop_cnt); end
    endtask

    task automatic test_backpressure();
        int g0, s0;
        do_reset();
        exp_q.delete();
        g0 = got_q.size();
        s0 = stall_err;
        fork
            send_frame(40, 40, 0, 3);
            begin
                for (int k = 0; k < 150; k++) begin
                    m_tready = ~m_tready;
                    @(posedge sys_clk); #1;
                end
                m_tready = 1'b1;
            end
        join
        add_exp(36, 0);
        wait_out(g0 + 36, 200);
        total++; if (got_q.size() - g0 != exp_q.size()) begin bad++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size() - g0, exp_q.size()); end
        for (int i = 0; (i < exp_q.size()) && (g0 + i < got_q.size()); i++) begin
            total++;
            if (got_q[g0 + i] !== exp_q[i]) begin bad++; $display("FAIL bp_byte%0d got=%h exp=%h", i, got_q[g0 + i], exp_q[i]); end
        end
        total++; if (stall_err != s0)     begin bad++; $display("FAIL bp_hold got=%0d exp=0 unstable stalls", stall_err - s0); end
        total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL bp_frame_cnt got=%0d exp=1", frame_cnt); end
    endtask

    task automatic test_trunc();
        int g0, e0;
        do_reset();
        exp_q.delete();
        g0 = got_q.size();
        e0 = err_pulses;
        send_frame(100, 60, 0, 4);
        total++; if (err_pulses - e0 != 1) begin bad++; $display("FAIL trunc_pulse got=%0d exp=1", err_pulses - e0); end
        total++; if (drop_cnt !== 16'd1)   begin bad++; $display("FAIL trunc_drop_cnt got=%0d exp=1", drop_cnt); end
        total++; if (got_q.size() != g0)   begin bad++; $display("FAIL trunc_no_output got=%0d exp=0", got_q.size() - g0); end
        send_frame(40, 40, 8'h40, 3);
        add_exp(36, 8'h40);
        wait_out(g0 + 36, 200);
        total++; if (got_q.size() - g0 != exp_q.size()) begin bad++; $display("FAIL trunc_count got=%0d exp=%0d", got_q.size() - g0, exp_q.size()); end
        for (int i = 0; (i < exp_q.size()) && (g0 + i < got_q.size()); i++) begin
            total++;
            if (got_q[g0 + i] !== exp_q[i]) begin bad++; $display("FAIL trunc_byte%0d got=%h exp=%h", i, got_q[g0 + i], exp_q[i]); end
        end
        total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL trunc_frame_cnt got=%0d exp=1", frame_cnt); end
    endtask

    task automatic test_full();
        int g0;
        do_reset();
        exp_q.delete();
        m_tready = 1'b0;
        g0 = got_q.size();
        send_frame(1540, 1540, 8'h00, 2);
        send_frame(1540, 1540, 8'h10, 2);
        send_frame(1540, 1540, 8'h20, 2);
        total++; if (drop_cnt !== 16'd1)   begin bad++; $display("FAIL full_drop_cnt got=%0d exp=1", drop_cnt); end
        total++; if (m_tvalid !== 1'b1)    begin bad++; $display("FAIL full_tvalid got=%b exp=1", m_tvalid); end
        total++; if (m_tlen !== 16'd1536)  begin bad++; $display("FAIL full_tlen got=%0d exp=1536", m_tlen); end
        total++; if (m_tdata !== 8'h04)    begin bad++; $display("FAIL full_tdata got=%h exp=04", m_tdata); end
        m_tready = 1'b1;
        add_exp(1536, 8'h00);
        add_exp(1536, 8'h10);
        wait_out(g0 + 3072, 4000);
        total++; if (got_q.size() - g0 != exp_q.size()) begin bad++; $display("FAIL full_count got=%0d exp=%0d", got_q.size() - g0, exp_q.size()); end
        for (int i = 0; (i < exp_q.size()) && (g0 + i < got_q.size()); i++) begin
            total++;
            if (got_q[g0 + i] !== exp_q[i]) begin bad++; $display("FAIL full_byte%0d got=%h exp=%h", i, got_q[g0 + i], exp_q[i]); end
        end
        total++; if (frame_cnt !== 16'd2) begin bad++; $display("FAIL full_frame_cnt got=%0d exp=2", frame_cnt); end
    endtask

    task automatic test_illegal();
        int g0;
        do_reset();
        g0 = got_q.size();
        send_frame(4, 4, 0, 3);
        send_frame(1541, 1541, 0, 3);
        repeat (10) @(posedge sys_clk);
        #1;
        total++; if (drop_cnt !== 16'd2) begin bad++; $display("FAIL illegal_drop_cnt got=%0d exp=2", drop_cnt); end
        total++; if (m_tvalid !== 1'b0)  begin bad++; $display("FAIL illegal_tvalid got=%b exp=0", m_tvalid); end
        total++; if (got_q.size() != g0) begin bad++; $display("FAIL illegal_output got=%0d exp=0", got_q.size() - g0); end
    endtask

    task automatic test_back_to_back();
        int g0;
        do_reset();
        exp_q.delete();
        g0 = got_q.size();
        for (int k = 0; k < 200; k++) begin
            send_frame(100, 100, k * 3, (k == 199) ? 3 : 0);
            add_exp(96, k * 3);
        end
        wait_out(g0 + 19200, 2000);
        total++; if (got_q.size() - g0 != exp_q.size()) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size() - g0, exp_q.size()); end
        for (int i = 0; (i < exp_q.size()) && (g0 + i < got_q.size()); i++) begin
            total++;
            if (got_q[g0 + i] !== exp_q[i]) begin bad++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, got_q[g0 + i], exp_q[i]); end
        end
        total++; if (frame_cnt !== 16'd200) begin bad++; $display("FAIL b2b_frame_cnt got=%0d exp=200", frame_cnt); end
        total++; if (drop_cnt !== 16'd0)    begin bad++; $display("FAIL b2b_drop_cnt got=%0d exp=0", drop_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_trunc();
        test_full();
        test_illegal();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
